// File: rtl/div_seq_32.sv
// div_seq_32 -- multi-cycle restoring divider beside the EX-stage ALU.
//   One quotient bit per clock through a single shared add_sub_32 (subtract).
//   Sequence: IDLE -> PREP -> ITER x N -> FIX -> DONE -> IDLE.
//   Latency: done in the 35th cycle after the accepting edge, 2nd for divide-by-zero.
// Ports:
//   clk, reset        rising-edge clock, asynchronous active-high reset
//   start             request, sampled only in IDLE
//   is_signed         two's-complement divide when SIGNED_EN=1, sampled with start
//   dividend, divisor operands, sampled with start
//   busy              high from the cycle after accept through the DONE cycle
//   done              one-cycle pulse, results valid and held afterwards
//   quotient          truncates toward zero
//   remainder         takes the sign of the dividend
//   div_by_zero       divisor was 0 (quotient all ones, remainder = dividend)

module add_sub_32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        sel,   // 1 = a - b
    output logic [31:0] sum,
    output logic        cout   // on subtract: 1 = no borrow
);
    logic [32:0] res;
    assign res  = {1'b0, a} + {1'b0, (sel ? ~b : b)} + {32'b0, sel};
    assign sum  = res[31:0];
    assign cout = res[32];
endmodule

module div_seq_32 #(
    parameter int N         = 32,  // only 32 is legal: the shared adder is 32-bit
    parameter int SIGNED_EN = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         is_signed,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         div_by_zero
);
    localparam int CW = $clog2(N);

    typedef enum logic [2:0] {S_IDLE, S_PREP, S_ITER, S_FIX, S_DONE} state_t;
    state_t state, state_nx;

    logic [N-1:0]  a_lat, b_lat;
    logic          sgn_lat;
    logic [N-1:0]  rem, quo, dmag;
    logic [CW-1:0] cnt;
    logic          neg_q, neg_r;

    logic          a_neg, b_neg;
    logic [N-1:0]  rem_sh, diff;
    logic          cout, take;

    assign a_neg  = sgn_lat & a_lat[N-1];
    assign b_neg  = sgn_lat & b_lat[N-1];
    assign rem_sh = {rem[N-2:0], quo[N-1]};

    add_sub_32 u_addsub (
        .a    (rem_sh),
        .b    (dmag),
        .sel  (1'b1),
        .sum  (diff),
        .cout (cout)
    );

    // The shifted partial remainder is really N+1 bits wide; the bit shifted
    // out (rem[N-1]) means it already exceeds any N-bit divisor, so the
    // subtract must be taken and the wrapped difference is still exact.
    assign take = cout | rem[N-1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        busy     = 1'b1;
        done     = 1'b0;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) state_nx = S_PREP;
            end
            S_PREP:  state_nx = (b_lat == '0) ? S_DONE : S_ITER;
            S_ITER:  if (cnt == CW'(N - 1)) state_nx = S_FIX;
            S_FIX:   state_nx = S_DONE;
            S_DONE: begin
                done     = 1'b1;
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_lat       <= '0;
            b_lat       <= '0;
            sgn_lat     <= 1'b0;
            rem         <= '0;
            quo         <= '0;
            dmag        <= '0;
            cnt         <= '0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    a_lat       <= dividend;
                    b_lat       <= divisor;
                    sgn_lat     <= (SIGNED_EN != 0) && is_signed;
                    div_by_zero <= 1'b0;
                end
                S_PREP: if (b_lat == '0) begin
                    quotient    <= '1;
                    remainder   <= a_lat;
                    div_by_zero <= 1'b1;
                end else begin
                    // |-2^31| = 32'h8000_0000 is exact as an unsigned magnitude
                    quo   <= a_neg ? -a_lat : a_lat;
                    dmag  <= b_neg ? -b_lat : b_lat;
                    neg_q <= a_neg ^ b_neg;
                    neg_r <= a_neg;
                    rem   <= '0;
                    cnt   <= '0;
                end
                S_ITER: begin
                    quo <= {quo[N-2:0], take};
                    rem <= take ? diff : rem_sh;
                    cnt <= cnt + 1'b1;
                end
                S_FIX: begin
                    quotient  <= neg_q ? -quo : quo;
                    remainder <= neg_r ? -rem : rem;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_div_seq_32.sv
module tb_div_seq_32;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        is_signed = 1'b0;
    logic [31:0] dividend = '0;
    logic [31:0] divisor = '0;
    logic        busy, done, div_by_zero;
    logic [31:0] quotient, remainder;

    int n_tests = 0;
    int n_fail  = 0;

    div_seq_32 dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .is_signed   (is_signed),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference result {div_by_zero, quotient, remainder} from plain 64-bit arithmetic.
    function automatic logic [64:0] ref_div(input logic [31:0] a, input logic [31:0] b, input logic s);
        longint x, y;
        if (b == 32'd0) return {1'b1, 32'hFFFF_FFFF, a};
        if (s) begin
            x = longint'($signed(a));
            y = longint'($signed(b));
        end else begin
            x = longint'({32'd0, a});
            y = longint'({32'd0, b});
        end
        return {1'b0, 32'(x / y), 32'(x % y)};
    endfunction

    // Transaction-level model: cycles remaining until the end of the op,
    // pending result, and the result that is held while idle.
    int          m_left;
    logic [64:0] pend, held;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_left <= 0;
            pend   <= '0;
            held   <= '0;
        end else if (m_left > 0) begin
            if (m_left == 1) held <= pend;
            m_left <= m_left - 1;
        end else if (start) begin
            pend     <= ref_div(dividend, divisor, is_signed);
            held[64] <= 1'b0;
            m_left   <= (divisor == 32'd0) ? 2 : 35;
        end
    end

    always @(negedge clk) begin
        chk("busy", {31'd0, busy}, {31'd0, m_left > 0});
        chk("done", {31'd0, done}, {31'd0, m_left == 1});
        if (m_left == 1) begin
            chk("quotient@done", quotient, pend[63:32]);
            chk("remainder@done", remainder, pend[31:0]);
            chk("dbz@done", {31'd0, div_by_zero}, {31'd0, pend[64]});
        end else begin
            chk("dbz_hold", {31'd0, div_by_zero}, {31'd0, held[64]});
            if (m_left == 0) begin
                chk("quotient_hold", quotient, held[63:32]);
                chk("remainder_hold", remainder, held[31:0]);
            end
        end
    end

    // Drive one op from a negedge in IDLE, wait for done, compare to literals.
    task automatic run_op(input string nm, input logic [31:0] a, input logic [31:0] b, input logic s,
                          input logic [31:0] eq, input logic [31:0] er, input logic edz,
                          input int elat, input bit repulse);
        int n;
        start = 1'b1; is_signed = s; dividend = a; divisor = b;
        @(negedge clk);
        start = 1'b0; dividend = $urandom; divisor = $urandom; is_signed = $urandom_range(0, 1);
        n = 1;
        while (!done && n < 60) begin
            @(negedge clk);
            n++;
            if (repulse && n == 10) begin
                start = 1'b1; dividend = 32'd50; divisor = 32'd5; is_signed = 1'b0;
            end else begin
                start = 1'b0;
            end
        end
        chk({nm, "_lat"}, 32'(n), 32'(elat));
        chk({nm, "_q"}, quotient, eq);
        chk({nm, "_r"}, remainder, er);
        chk({nm, "_dbz"}, {31'd0, div_by_zero}, {31'd0, edz});
    endtask

    function automatic logic [31:0] pick(input bit allow_zero);
        case ($urandom_range(0, 7))
            0: return allow_zero ? 32'd0 : 32'd3;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'(signed'($urandom_range(0, 15)) - 8);
            4: return 32'($urandom_range(1, 300));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        repeat (2) @(negedge clk);
        chk("reset_q", quotient, 32'd0);
        chk("reset_r", remainder, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        run_op("u100_7", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0, 35, 1'b0);
        @(negedge clk);
        run_op("sm100_7", 32'hFFFF_FF9C, 32'd7, 1'b1, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0, 35, 1'b0);
        @(negedge clk);
        run_op("div0", 32'h1234_5678, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'h1234_5678, 1'b1, 2, 1'b0);
        @(negedge clk);
        run_op("sovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0, 1'b0, 35, 1'b0);
        @(negedge clk);
        run_op("umax_1", 32'hFFFF_FFFF, 32'd1, 1'b0, 32'hFFFF_FFFF, 32'd0, 1'b0, 35, 1'b0);
        @(negedge clk);
        run_op("repulse", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0, 35, 1'b1);
        @(negedge clk);
        run_op("s7_m2", 32'd7, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1, 1'b0, 35, 1'b0);

        // Asynchronous reset in the middle of an operation.
        @(negedge clk);
        start = 1'b1; is_signed = 1'b0; dividend = 32'd1000; divisor = 32'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (19) @(negedge clk);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_done", {31'd0, done}, 32'd0);
        chk("arst_q", quotient, 32'd0);
        chk("arst_r", remainder, 32'd0);
        chk("arst_dbz", {31'd0, div_by_zero}, 32'd0);
        @(negedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        run_op("post_rst", 32'd1000, 32'd3, 1'b0, 32'd333, 32'd1, 1'b0, 35, 1'b0);

        // Random traffic: starts land while busy, in DONE and in IDLE.
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            start     = ($urandom_range(0, 3) == 0);
            is_signed = $urandom_range(0, 1);
            dividend  = pick(1'b0);
            divisor   = pick(1'b1);
        end
        @(negedge clk);
        start = 1'b0;
        repeat (40) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
